// File: rtl/score_lives_ctrl.sv
// Score and lives controller for a paddle game: tracks score, remaining balls,
// serve delay after a miss, and the best final score since reset.
module score_lives_ctrl #(
    parameter int unsigned WIN_SCORE    = 12,
    parameter int unsigned START_LIVES  = 3,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    output logic [3:0] score,
    output logic [1:0] ball,
    output logic [3:0] hi_score,
    output logic       serve_hold,
    output logic       game_over,
    output logic       won
);

    localparam logic [3:0] WIN        = 4'(WIN_SCORE);
    localparam logic [1:0] LIVES      = 2'(START_LIVES);
    localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);

    typedef enum logic [1:0] {IDLE, PLAY, SERVE, OVER} state_t;

    state_t     state, state_n;
    logic [3:0] score_n, hi_n;
    logic [1:0] ball_n;
    logic [7:0] serve_cnt, serve_cnt_n;
    logic       hit_prev, hit_prev_n;
    logic       won_n;
    logic       armed, armed_n;   // start has been seen low while in OVER

    logic [3:0] score_inc;
    logic [1:0] ball_dec;

    assign score_inc = score + 4'd1;
    assign ball_dec  = ball - 2'd1;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
        state_n     = state;
        score_n     = score;
        ball_n      = ball;
        hi_n        = hi_score;
        serve_cnt_n = serve_cnt;
        hit_prev_n  = hit_prev;
        won_n       = won;
        armed_n     = armed;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = PLAY;
                    score_n    = 4'd0;
                    ball_n     = LIVES;
                    hit_prev_n = 1'b0;
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    hit_prev_n = hit;
                    if (miss) begin
                        ball_n = ball_dec;
                        if (ball_dec == 2'd0) begin
                            state_n = OVER;
                            armed_n = 1'b0;
                            if (score > hi_score) hi_n = score;
                        end else begin
                            state_n     = SERVE;
                            serve_cnt_n = SERVE_LOAD;
                        end
                    end else if (hit && !hit_prev) begin
                        score_n = score_inc;
                        if (score_inc == WIN) begin
                            state_n = OVER;
                            won_n   = 1'b1;
                            armed_n = 1'b0;
                            if (score_inc > hi_score) hi_n = score_inc;
                        end
                    end
                end
            end
            SERVE: begin
                // Counter reaching zero releases play on the following cycle.
                if (serve_cnt == 8'd0) begin
                    state_n    = PLAY;
                    hit_prev_n = 1'b0;
                end else if (frame_tick) begin
                    serve_cnt_n = serve_cnt - 8'd1;
                end
            end
            OVER: begin
                if (!start) begin
                    armed_n = 1'b1;
                end else if (armed) begin
                    state_n    = PLAY;
                    score_n    = 4'd0;
                    ball_n     = LIVES;
                    won_n      = 1'b0;
                    hit_prev_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            score     <= 4'd0;
            ball      <= LIVES;
            hi_score  <= 4'd0;
            serve_cnt <= 8'd0;
            hit_prev  <= 1'b0;
            won       <= 1'b0;
            armed     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_n;
            score     <= score_n;
            ball      <= ball_n;
            hi_score  <= hi_n;
            serve_cnt <= serve_cnt_n;
            hit_prev  <= hit_prev_n;
            won       <= won_n;
            armed     <= armed_n;
        end
    end

    assign serve_hold = (state != PLAY);
    assign game_over  = (state == OVER);

endmodule

// File: tb/tb_score_lives_ctrl.sv
// Self-checking bench for score_lives_ctrl: directed scenarios plus a randomized
// run compared against a game-rule reference model.
module tb_score_lives_ctrl;

    localparam int WIN   = 12;
    localparam int LIVES = 3;
    localparam int SERVE = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic [3:0] score;
    logic [1:0] ball;
    logic [3:0] hi_score;
    logic       serve_hold;
    logic       game_over;
    logic       won;

    int checks = 0;
    int failures = 0;

    score_lives_ctrl #(.WIN_SCORE(WIN), .START_LIVES(LIVES), .SERVE_FRAMES(SERVE)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .hit(hit), .miss(miss),
        .score(score), .ball(ball), .hi_score(hi_score),
        .serve_hold(serve_hold), .game_over(game_over), .won(won)
    );

    always #5 clk = ~clk;

    // Reference model: game modes and counters kept as plain integers.
    localparam int M_IDLE = 0, M_PLAY = 1, M_SERVE = 2, M_OVER = 3;
    int m_mode, m_score, m_ball, m_hi, m_wait;
    bit m_prev, m_won, m_armed;

    task automatic model_reset();
        m_mode = M_IDLE; m_score = 0; m_ball = LIVES; m_hi = 0;
        m_wait = 0; m_prev = 0; m_won = 0; m_armed = 0;
    endtask

    task automatic model_enter_over();
        m_mode  = M_OVER;
        m_armed = 0;
        if (m_score > m_hi) m_hi = m_score;
    endtask

    task automatic model_new_game();
        m_mode = M_PLAY; m_score = 0; m_ball = LIVES; m_won = 0; m_prev = 0;
    endtask

    task automatic model_step(input bit s, input bit t, input bit h, input bit m);
        case (m_mode)
            M_IDLE: if (s) model_new_game();
            M_PLAY: if (t) begin
                if (m) begin
                    m_ball = m_ball - 1;
                    if (m_ball == 0) model_enter_over();
                    else begin m_mode = M_SERVE; m_wait = SERVE; end
                end else if (h && !m_prev) begin
                    m_score = m_score + 1;
                    if (m_score == WIN) begin m_won = 1; model_enter_over(); end
                end
                m_prev = h;
            end
            M_SERVE: begin
                if (m_wait == 0) begin m_mode = M_PLAY; m_prev = 0; end
                else if (t) m_wait = m_wait - 1;
            end
            default: begin
                if (!s) m_armed = 1;
                else if (m_armed) model_new_game();
            end
        endcase
    endtask

    task automatic step(input bit s, input bit t, input bit h, input bit m);
        start = s; frame_tick = t; hit = h; miss = m;
        model_step(s, t, h, m);
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input bit h, input bit m);
        step(0, 1, h, m);
        step(0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        start = 0; frame_tick = 0; hit = 0; miss = 0;
        rst = 1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (score !== 4'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", score); end
        checks++; if (ball !== 2'd3) begin failures++; $display("FAIL reset_ball got=%0d exp=3", ball); end
        checks++; if (hi_score !== 4'd0) begin failures++; $display("FAIL reset_hi got=%0d exp=0", hi_score); end
        checks++; if ({serve_hold, game_over, won} !== 3'b100) begin failures++; $display("FAIL reset_flags got=%b exp=100", {serve_hold, game_over, won}); end
        repeat (4) tick(1, 1);
        checks++; if (serve_hold !== 1'b1 || ball !== 2'd3 || score !== 4'd0) begin failures++; $display("FAIL idle_no_start hold=%b ball=%0d score=%0d exp hold=1 ball=3 score=0", serve_hold, ball, score); end
    endtask

    task automatic test_basic_hits();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        tick(1, 0); tick(0, 0); tick(1, 0);
        checks++; if (score !== 4'd2) begin failures++; $display("FAIL basic_score got=%0d exp=2", score); end
        checks++; if (ball !== 2'd3) begin failures++; $display("FAIL basic_ball got=%0d exp=3", ball); end
        checks++; if (serve_hold !== 1'b0) begin failures++; $display("FAIL basic_hold got=%b exp=0", serve_hold); end
    endtask

    task automatic test_edge_credit();
        tick(0, 0);
        repeat (5) tick(1, 0);
        checks++; if (score !== 4'd3) begin failures++; $display("FAIL edge_credit got=%0d exp=3", score); end
    endtask

    task automatic test_miss_priority();
        tick(0, 0);
        tick(1, 1);
        checks++; if (score !== 4'd3 || ball !== 2'd2) begin failures++; $display("FAIL miss_prio score=%0d ball=%0d exp score=3 ball=2", score, ball); end
        checks++; if (serve_hold !== 1'b1) begin failures++; $display("FAIL serve_entry hold=%b exp=1", serve_hold); end
        step(1, 1, 1, 0);
        step(0, 0, 0, 0);
        repeat (SERVE - 2) tick(0, 0);
        checks++; if (serve_hold !== 1'b1 || score !== 4'd3) begin failures++; $display("FAIL serve_59 hold=%b score=%0d exp hold=1 score=3", serve_hold, score); end
        tick(0, 0);
        checks++; if (serve_hold !== 1'b0) begin failures++; $display("FAIL serve_60 hold=%b exp=0", serve_hold); end
        tick(1, 0);
        checks++; if (score !== 4'd4) begin failures++; $display("FAIL after_serve_credit got=%0d exp=4", score); end
    endtask

    task automatic test_loss();
        apply_reset();
        step(1, 0, 0, 0);
        repeat (4) begin tick(1, 0); tick(0, 0); end
        repeat (2) begin tick(0, 1); repeat (SERVE) tick(0, 0); end
        checks++; if (ball !== 2'd1 || serve_hold !== 1'b0) begin failures++; $display("FAIL loss_pre ball=%0d hold=%b exp ball=1 hold=0", ball, serve_hold); end
        tick(0, 1);
        checks++; if (ball !== 2'd0 || score !== 4'd4) begin failures++; $display("FAIL loss_ball ball=%0d score=%0d exp ball=0 score=4", ball, score); end
        checks++; if ({game_over, won} !== 2'b10) begin failures++; $display("FAIL loss_flags got=%b exp=10", {game_over, won}); end
        checks++; if (hi_score !== 4'd4) begin failures++; $display("FAIL loss_hi got=%0d exp=4", hi_score); end
        repeat (3) begin tick(1, 0); tick(0, 1); end
        checks++; if (score !== 4'd4 || ball !== 2'd0) begin failures++; $display("FAIL loss_frozen score=%0d ball=%0d exp score=4 ball=0", score, ball); end
    endtask

    task automatic test_win();
        step(1, 0, 0, 0);
        checks++; if (score !== 4'd0 || ball !== 2'd3 || hi_score !== 4'd4) begin failures++; $display("FAIL restart1 score=%0d ball=%0d hi=%0d exp 0/3/4", score, ball, hi_score); end
        repeat (WIN - 1) begin tick(1, 0); tick(0, 0); end
        checks++; if (score !== 4'd11 || game_over !== 1'b0) begin failures++; $display("FAIL win_pre score=%0d over=%b exp score=11 over=0", score, game_over); end
        step(1, 1, 1, 0);
        repeat (5) step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        checks++; if (score !== 4'd12) begin failures++; $display("FAIL win_score got=%0d exp=12", score); end
        checks++; if ({serve_hold, game_over, won} !== 3'b111) begin failures++; $display("FAIL win_flags got=%b exp=111", {serve_hold, game_over, won}); end
        checks++; if (hi_score !== 4'd12) begin failures++; $display("FAIL win_hi got=%0d exp=12", hi_score); end
        step(0, 0, 0, 0);
        checks++; if (game_over !== 1'b1) begin failures++; $display("FAIL win_hold_start over=%b exp=1", game_over); end
        step(1, 0, 0, 0);
        checks++; if (score !== 4'd0 || ball !== 2'd3 || hi_score !== 4'd12) begin failures++; $display("FAIL restart2 score=%0d ball=%0d hi=%0d exp 0/3/12", score, ball, hi_score); end
        checks++; if ({serve_hold, game_over, won} !== 3'b000) begin failures++; $display("FAIL restart2_flags got=%b exp=000", {serve_hold, game_over, won}); end
    endtask

    task automatic test_reset_in_serve();
        repeat (7) begin tick(1, 0); tick(0, 0); end
        tick(0, 1);
        repeat (5) tick(0, 0);
        checks++; if (score !== 4'd7 || serve_hold !== 1'b1 || ball !== 2'd2) begin failures++; $display("FAIL pre_rst score=%0d hold=%b ball=%0d exp 7/1/2", score, serve_hold, ball); end
        #3;
        rst = 1;
        model_reset();
        #1;
        checks++; if (score !== 4'd0 || ball !== 2'd3 || hi_score !== 4'd0) begin failures++; $display("FAIL async_rst score=%0d ball=%0d hi=%0d exp 0/3/0", score, ball, hi_score); end
        checks++; if ({serve_hold, game_over, won} !== 3'b100) begin failures++; $display("FAIL async_rst_flags got=%b exp=100", {serve_hold, game_over, won}); end
        @(posedge clk);
        #1;
        rst = 0;
        repeat (3) tick(1, 0);
        checks++; if (serve_hold !== 1'b1 || score !== 4'd0) begin failures++; $display("FAIL post_rst_idle hold=%b score=%0d exp hold=1 score=0", serve_hold, score); end
    endtask

    task automatic test_random();
        bit s, t, h, m;
        apply_reset();
        for (int i = 0; i < 6000; i++) begin
            s = ($urandom_range(0, 19) == 0);
            t = ($urandom_range(0, 2) == 0);
            h = $urandom_range(0, 1) == 1;
            m = ($urandom_range(0, 24) == 0);
            step(s, t, h, m);
            checks++;
            if (score !== 4'(m_score) || ball !== 2'(m_ball) || hi_score !== 4'(m_hi) ||
                serve_hold !== (m_mode != M_PLAY) || game_over !== (m_mode == M_OVER) || won !== m_won) begin
                failures++;
                $display("FAIL random_cyc%0d got s=%0d b=%0d hi=%0d hold=%b over=%b won=%b exp s=%0d b=%0d hi=%0d hold=%b over=%b won=%b",
                         i, score, ball, hi_score, serve_hold, game_over, won,
                         m_score, m_ball, m_hi, (m_mode != M_PLAY), (m_mode == M_OVER), m_won);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_hits();
        test_edge_credit();
        test_miss_priority();
        test_loss();
        test_win();
        test_reset_in_serve();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
